enc16_serializer: RTL and testbench
===================================

Name: enc16_serializer

Overview:
- Inverse of the 4-to-16 one-hot decoder. Accepts a 16-bit multi-hot request vector and emits the 4-bit index of each set bit, one per beat, over a valid/ready stream.
- Index k maps to bit k, which matches the decoder (sel = k drives out = 1 << k). A downstream 4-to-16 decoder therefore reconstructs each bit exactly.
- Sits between status/interrupt vectors and any consumer that takes one encoded select at a time.

Parameters:
- LSB_FIRST, default 1: when 1, the lowest set bit is emitted first; when 0, the highest set bit is emitted first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_vec  input  16  request vector; sampled only on accept.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- out_idx  output  4  encoded index of the current set bit.
- out_valid  output  1  out_idx and out_last are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_last  output  1  current beat is the final index of the accepted vector.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state = IDLE, pending = 16'h0000, out_valid = 0, out_idx = 4'h0, out_last = 0, in_ready = 1 (the first cycle after rst deasserts).
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - DRAIN: in_ready = 0, out_valid = 1.
- IDLE, in_valid = 1, in_vec != 0: latch in_vec into pending; go to DRAIN. The first beat is valid the next cycle (latency 1).
- IDLE, in_valid = 1, in_vec == 0: the vector is accepted and dropped. No output beat. Stay in IDLE.
- DRAIN beat contents:
  - out_idx = priority-encoded index of pending (LSB or MSB first per LSB_FIRST).
  - out_last = 1 when popcount(pending) == 1.
- DRAIN, out_ready = 1: clear the emitted bit in pending.
  - If the beat was last, go to IDLE; in_ready = 1 the following cycle.
  - Otherwise the next index is presented the next cycle. Throughput is 1 index/cycle.
- DRAIN, out_ready = 0: out_idx, out_last and out_valid hold stable. Never retract or change a beat while it is stalled.
- Vector turnaround: there is one idle cycle between the last beat of one vector and acceptance of the next. There is no bypass of in_vec to the outputs.
- All outputs are registered or decoded from state/pending only. There is no combinational path from in_* or out_ready to any output.
- out_idx is a don't-care when out_valid = 0, but it is held at its last value (not X).
- Boundaries:
  - in_vec = 16'hFFFF produces 16 beats.
  - A single-bit vector produces 1 beat with out_last = 1.
  - in_vec changes while in DRAIN are ignored.
- Reset mid-operation: pending is discarded and out_valid = 0 the next cycle, with no partial completion.
- rst has priority over every other event in the same cycle.

Decomposition:
- Package enc16_pkg:
  - vec_t = logic [15:0]
  - idx_t = logic [3:0]
  - state_t enum {IDLE, DRAIN}
  - constant VEC_W = 16
- Sub-module pri_enc16: purely combinational.
  - Inputs: vec_t, parameter LSB_FIRST.
  - Outputs: idx_t idx, logic any, logic one_left (popcount == 1).
  - The top level holds only the FSM and the pending register.

Test Plan:
- Reset, then in_vec = 16'h8001, out_ready = 1 -> beats idx 0 (last 0), idx 15 (last 1) on consecutive cycles; in_ready = 1 on the cycle after.
- in_vec = 16'hFFFF, LSB_FIRST = 1, out_ready = 1 -> 16 beats idx 0..15 back-to-back; out_last only on idx 15. With LSB_FIRST = 0 -> idx 15..0, out_last on idx 0.
- in_vec = 16'h0410, out_ready low for 3 cycles on the first beat -> idx 4 held stable for 4 cycles with out_valid = 1, then idx 10 with last = 1.
- in_vec = 16'h0000 with in_valid = 1 -> in_ready stays 1, out_valid never asserts; a following 16'h0020 yields a single beat idx 5, last = 1.
- rst asserted while draining 16'h00F0 after beat idx 4 -> next cycle out_valid = 0, in_ready = 1; no further beats.
- Loopback: the output stream drives a 4-to-16 decoder (en = out_valid) and its outputs are OR-accumulated over random vectors -> accumulated result equals each in_vec.

Source files
------------

// File: rtl/enc16_pkg.sv
// Shared types and constants for the 16-bit multi-hot to index serializer.
package enc16_pkg;

    localparam int VEC_W = 16;

    typedef logic [VEC_W-1:0] vec_t;
    typedef logic [3:0]       idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // One-hot mask for an index; matches the downstream 4-to-16 decoder.
    function automatic vec_t onehot(input idx_t idx);
        return vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/pri_enc16.sv
// Combinational priority encoder for a 16-bit vector.
// LSB_FIRST=1 picks the lowest set bit, LSB_FIRST=0 the highest.
// one_left flags a vector with exactly one bit set.
module pri_enc16
    import enc16_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  vec_t vec,
    output idx_t idx,
    output logic any,
    output logic one_left
);

    vec_t ord;
    idx_t pos;

    // Reorder the vector so the preferred end always sits at bit 0.
    generate
        for (genvar gi = 0; gi < VEC_W; gi++) begin : g_ord
            if (LSB_FIRST) begin : g_lsb
                assign ord[gi] = vec[gi];
            end else begin : g_msb
                assign ord[gi] = vec[VEC_W-1-gi];
            end
        end
    endgenerate

    // Lowest set position of the reordered vector (later iterations win).
    always_comb begin
        pos = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (ord[i]) begin
                pos = idx_t'(i);
            end
        end
    end

    assign idx      = LSB_FIRST ? pos : (idx_t'(VEC_W - 1) - pos);
    assign any      = |vec;
    assign one_left = any && ((vec & (vec - vec_t'(1))) == '0);

endmodule

// File: rtl/enc16_serializer.sv
// Serializes a 16-bit multi-hot request vector into a stream of 4-bit
// indices, one per beat, over valid/ready. All outputs are registered.
module enc16_serializer
    import enc16_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_vec,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  out_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    state_t state_reg;
    vec_t   pending_reg;
    vec_t   pending_next;
    idx_t   out_idx_reg;
    logic   out_valid_reg;
    logic   out_last_reg;
    logic   in_ready_reg;

    idx_t   next_idx;
    logic   next_any;
    logic   next_last;

    // Pending vector after this cycle: load on accept, clear the emitted
    // bit on a taken beat, otherwise hold. A zero vector loads as empty and
    // is therefore dropped without producing a beat.
    always_comb begin
        pending_next = pending_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    pending_next = in_vec;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    pending_next = pending_reg & ~onehot(out_idx_reg);
                end
            end
            default: ;
        endcase
    end

    // Encode the upcoming pending vector so the next beat is ready to
    // register on this edge, giving one index per cycle.
    pri_enc16 #(
        .LSB_FIRST(LSB_FIRST)
    ) u_enc (
        .vec     (pending_next),
        .idx     (next_idx),
        .any     (next_any),
        .one_left(next_last)
    );

    // FSM and registered outputs; the beat only moves when pending moves,
    // so a stalled beat stays stable. out_idx keeps its last value in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_last_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            pending_reg   <= pending_next;
            state_reg     <= next_any ? DRAIN : IDLE;
            out_valid_reg <= next_any;
            in_ready_reg  <= !next_any;
            if (next_any) begin
                out_idx_reg  <= next_idx;
                out_last_reg <= next_last;
            end else begin
                out_last_reg <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_enc16_serializer.sv
// Scoreboard bench: two DUTs (lowest-first and highest-first) share the
// input stream and out_ready; a monitor compares each taken beat against
// queued expectations and reassembles vectors through a decoder.
module tb_enc16_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_vec = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_l, out_valid_l, out_last_l;
    logic [3:0]  out_idx_l;
    logic        in_ready_m, out_valid_m, out_last_m;
    logic [3:0]  out_idx_m;

    int total = 0;
    int bad = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    logic [4:0]  q_l[$];
    logic [4:0]  q_m[$];
    logic [15:0] q_vec[$];
    logic [15:0] acc = '0;
    logic [4:0]  exp_l, exp_m;
    logic        prev_stall_l = 1'b0, prev_stall_m = 1'b0;
    logic [4:0]  prev_beat_l = '0, prev_beat_m = '0;

    enc16_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(in_ready_l), .out_idx(out_idx_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .out_last(out_last_l)
    );

    enc16_serializer #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(in_ready_m), .out_idx(out_idx_m), .out_valid(out_valid_m),
        .out_ready(out_ready), .out_last(out_last_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference model: list the set bits, then order and tag the last one.
    task automatic push_expect(input logic [15:0] v);
        int bits[$];
        for (int k = 0; k < 16; k++) if (v[k]) bits.push_back(k);
        for (int j = 0; j < bits.size(); j++) begin
            q_l.push_back({j == bits.size() - 1, 4'(bits[j])});
            q_m.push_back({j == bits.size() - 1, 4'(bits[bits.size() - 1 - j])});
        end
        if (v != 16'h0) q_vec.push_back(v);
    endtask

    task automatic send(input logic [15:0] v);
        int n = 0;
        @(negedge clk);
        while (!in_ready_l && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready_l, 1);
        chk("in_ready_match", in_ready_m, in_ready_l);
        in_vec = v;
        in_valid = 1'b1;
        push_expect(v);
        $display("send vec=%h", v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec = 16'($urandom);  // junk while draining must be ignored
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q_l.size() != 0 || q_m.size() != 0) && n < 1000) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain_left", q_l.size() + q_m.size(), 0);
    endtask

    // Consumer ready, changed just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: compare each taken beat, check stall stability, loopback.
    always @(negedge clk) begin
        if (rst) begin
            q_l.delete();
            q_m.delete();
            q_vec.delete();
            acc = '0;
        end else begin
            if (prev_stall_l) begin
                chk("hold_valid_lsb", out_valid_l, 1);
                chk("hold_beat_lsb", {out_last_l, out_idx_l}, prev_beat_l);
            end
            if (prev_stall_m) begin
                chk("hold_valid_msb", out_valid_m, 1);
                chk("hold_beat_msb", {out_last_m, out_idx_m}, prev_beat_m);
            end
            if (out_valid_l && out_ready) begin
                $display("beat lsb idx=%0d last=%0d", out_idx_l, out_last_l);
                if (q_l.size() == 0) begin
                    chk("lsb_unexpected_beat", 1, 0);
                end else begin
                    exp_l = q_l.pop_front();
                    chk("lsb_beat", {out_last_l, out_idx_l}, exp_l);
                end
                acc = acc | (16'h0001 << out_idx_l);
                if (out_last_l) begin
                    if (q_vec.size() == 0) chk("loopback_unexpected", 1, 0);
                    else chk("loopback", acc, q_vec.pop_front());
                    acc = '0;
                end
            end
            if (out_valid_m && out_ready) begin
                $display("beat msb idx=%0d last=%0d", out_idx_m, out_last_m);
                if (q_m.size() == 0) begin
                    chk("msb_unexpected_beat", 1, 0);
                end else begin
                    exp_m = q_m.pop_front();
                    chk("msb_beat", {out_last_m, out_idx_m}, exp_m);
                end
            end
        end
        prev_stall_l = !rst && out_valid_l && !out_ready;
        prev_stall_m = !rst && out_valid_m && !out_ready;
        prev_beat_l  = {out_last_l, out_idx_l};
        prev_beat_m  = {out_last_m, out_idx_m};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] v;
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready_l, 1);
        chk("rst_out_valid", out_valid_l, 0);
        chk("rst_out_idx", out_idx_l, 0);
        chk("rst_out_last", out_last_l, 0);
        chk("rst_out_valid_msb", out_valid_m, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready_l, 1);
        chk("post_rst_out_valid", out_valid_l, 0);

        // Two-bit vector, consecutive beats, then turnaround
        ready_mode = 0;
        send(16'h8001);
        @(negedge clk);
        chk("8001_b0", {out_valid_l, out_last_l, out_idx_l}, {2'b10, 4'd0});
        @(negedge clk);
        chk("8001_b1", {out_valid_l, out_last_l, out_idx_l}, {2'b11, 4'd15});
        @(negedge clk);
        chk("8001_in_ready", in_ready_l, 1);
        chk("8001_idle_valid", out_valid_l, 0);

        // Full vector back-to-back
        send(16'hFFFF);
        repeat (16) begin
            @(negedge clk);
            chk("ffff_b2b_valid", out_valid_l, 1);
        end
        @(negedge clk);
        chk("ffff_end_valid", out_valid_l, 0);
        chk("ffff_end_in_ready", in_ready_l, 1);

        // Stall on the first beat for three cycles
        ready_mode = 2;
        send(16'h0410);
        repeat (3) begin
            @(negedge clk);
            chk("stall_held", {out_valid_l, out_last_l, out_idx_l}, {2'b10, 4'd4});
        end
        ready_mode = 0;
        wait_drain();

        // Zero vector is accepted and dropped
        send(16'h0000);
        repeat (3) begin
            @(negedge clk);
            chk("zero_in_ready", in_ready_l, 1);
            chk("zero_out_valid", out_valid_l, 0);
        end
        send(16'h0020);
        @(negedge clk);
        chk("single_beat", {out_valid_l, out_last_l, out_idx_l}, {2'b11, 4'd5});
        wait_drain();

        // Reset in the middle of a drain
        send(16'h00F0);
        @(negedge clk);
        chk("mid_b0", out_idx_l, 4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid_l, 0);
        chk("mid_rst_in_ready", in_ready_l, 1);
        chk("mid_rst_out_valid_msb", out_valid_m, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_quiet", out_valid_l | out_valid_m, 0);
        end

        // Random vectors with random back-pressure
        ready_mode = 1;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0: v = 16'($urandom);
                1: v = 16'($urandom & $urandom & $urandom);
                2: v = 16'h0001 << $urandom_range(0, 15);
                3: v = 16'h0000;
                default: v = 16'($urandom | $urandom);
            endcase
            send(v);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        ready_mode = 0;
        wait_drain();
        @(negedge clk);
        @(negedge clk);
        chk("final_vec_queue", q_vec.size(), 0);
        chk("final_in_ready", in_ready_l, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
